led_toggle: RTL and testbench
=============================

// Module: led_toggle
// PURPOSE
//   Free-running LED blinker. A modulo-NUM_COUNT cycle counter toggles the LED
//   output each time it wraps, so the LED has a period of 2*NUM_COUNT clocks.
//   Top-level board block with no upstream handshake. Reused in simulation with
//   a small NUM_COUNT and in gate-level runs with the default.
// PARAMETERS
//   NUM_COUNT  50_000_000  clocks per LED half-period; legal range >= 1
//   COUNT_W    localparam = (NUM_COUNT>1) ? $clog2(NUM_COUNT) : 1; counter width
// PORTS
//   clk   input   1  single system clock; all state updates on the rising edge
//   rst   input   1  reset, asynchronous and active-high
//   led   output  1  LED drive, registered, active-high (1 = lit)
// BEHAVIOUR
//   - One clock domain (clk). Reset is asynchronous and active-high.
//   - Reset state: while rst=1, count_r=0 and led=0, independent of clk.
//     Release is sampled at the next rising clk edge.
//   - Internal counter register is named count_r, COUNT_W bits wide.
//     Benches probe it hierarchically (dut.count_r); keep this name and keep it
//     visible in the synthesized netlist.
//   - Each rising edge with rst=0:
//       count_r == NUM_COUNT-1 : count_r <= 0; led <= ~led
//       otherwise              : count_r <= count_r + 1; led holds
//   - Wrap compare is an exact equality against NUM_COUNT-1, truncated to
//     COUNT_W bits. count_r never exceeds NUM_COUNT-1.
//   - Latency: the first led rise occurs on the NUM_COUNT-th rising edge after
//     reset release. After that, led toggles every NUM_COUNT edges. Duty cycle
//     is exactly 50%.
//   - NUM_COUNT=1: count_r stays 0 and led toggles on every edge (clk/2).
//   - Reset mid-operation: count_r and led clear immediately. The sequence then
//     restarts from the beginning with no memory of the prior phase.
//   - led is driven directly from a flop, with no combinational path from any
//     input.
//   - No other outputs and no X-propagation after reset; all regs have reset
//     values.
//   - Elaboration check: NUM_COUNT < 1 is a fatal error
//     (generate-time $error / invalid instantiation).
// STRUCTURE
//   - Single module, no sub-modules required.
//   - Optionally factor the counter as sub-module mod_counter (params N, W;
//     outputs count, wrap), with led_toggle holding only the led flop.
//   - No shared package needed. COUNT_W stays a localparam computed in-module.
// TESTING  (clk period 10 ns, NUM_COUNT=5 unless stated)
//   1. Hold rst=1 for 15 ns -> count_r=0 and led=0 throughout, including
//      across clk edges.
//   2. Release rst, run 30 edges -> count_r cycles 1,2,3,4,0,...; led rises on
//      edge 5, falls on edge 10, rises on edge 15, and so on.
//   3. Assert rst asynchronously mid-count (count_r=3, led=1), between edges
//      -> count_r=0 and led=0 immediately. After release, the first toggle is
//      5 edges later.
//   4. NUM_COUNT=1 -> count_r remains 0; led alternates 1,0,1,... on
//      consecutive edges.
//   5. NUM_COUNT=8 (power of two, COUNT_W=3) -> count_r wraps 7->0 with no
//      overflow; led toggles every 8 edges.
//   6. Gate-level run with default NUM_COUNT -> led=0 and count_r
//      incrementing by 1 per edge after reset.

Source files
------------

// File: rtl/led_toggle_pkg.sv
// rtl/led_toggle_pkg.sv - shared constants for the LED blinker
package led_toggle_pkg;

  // Half-period at a 100 MHz board clock: a 1 Hz blink.
  localparam int DEFAULT_NUM_COUNT = 50_000_000;

endpackage

// File: rtl/led_toggle.sv
// rtl/led_toggle.sv - free-running LED blinker, toggles led every NUM_COUNT clocks
module led_toggle
  import led_toggle_pkg::*;
#(
  parameter int NUM_COUNT = DEFAULT_NUM_COUNT
) (
  input  logic clk,
  input  logic rst,
  output logic led
);

  localparam int COUNT_W = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(NUM_COUNT - 1);

  generate
    if (NUM_COUNT < 1) begin : g_bad_num_count
      $error("led_toggle: NUM_COUNT must be >= 1");
    end
  endgenerate

  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_d;
  logic               led_q;
  logic               led_d;
  logic               wrap;

  // Exact equality keeps count_r within 0..NUM_COUNT-1, including powers of two.
  always_comb begin
    wrap    = (count_r == LAST);
    count_d = wrap ? '0 : count_r + COUNT_W'(1);
    led_d   = wrap ? ~led_q : led_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      led_q   <= 1'b0;
    end else begin
      count_r <= count_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_toggle.sv
// tb/tb_led_toggle.sv - self-checking bench for led_toggle at NUM_COUNT 5, 1, 8 and default
module tb_led_toggle;

  logic clk;
  logic rst;
  logic led5;
  logic led1;
  logic led8;
  logic ledd;

  int errors = 0;
  int checks = 0;
  int n      = 0;

  localparam int NDEF = 50_000_000;

  led_toggle #(.NUM_COUNT(5)) dut  (.clk(clk), .rst(rst), .led(led5));
  led_toggle #(.NUM_COUNT(1)) dut1 (.clk(clk), .rst(rst), .led(led1));
  led_toggle #(.NUM_COUNT(8)) dut8 (.clk(clk), .rst(rst), .led(led8));
  led_toggle                  dutd (.clk(clk), .rst(rst), .led(ledd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: after n edges out of reset, the counter is n mod N and the led
  // has toggled floor(n/N) times.
  function automatic logic [31:0] exp_cnt(input int nc, input int edges);
    return 32'(edges % nc);
  endfunction

  function automatic logic [31:0] exp_led(input int nc, input int edges);
    return 32'((edges / nc) % 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
      end
  endtask

  task automatic check_all();
    check("cnt5", 32'(dut.count_r),  exp_cnt(5, n));
    check("led5", 32'(led5),         exp_led(5, n));
    check("cnt1", 32'(dut1.count_r), exp_cnt(1, n));
    check("led1", 32'(led1),         exp_led(1, n));
    check("cnt8", 32'(dut8.count_r), exp_cnt(8, n));
    check("led8", 32'(led8),         exp_led(8, n));
    check("cntd", 32'(dutd.count_r), exp_cnt(NDEF, n));
    check("ledd", 32'(ledd),         exp_led(NDEF, n));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cnt5"}, 32'(dut.count_r),  32'd0);
    check({tag, "_led5"}, 32'(led5),         32'd0);
    check({tag, "_cnt1"}, 32'(dut1.count_r), 32'd0);
    check({tag, "_led1"}, 32'(led1),         32'd0);
    check({tag, "_cnt8"}, 32'(dut8.count_r), 32'd0);
    check({tag, "_led8"}, 32'(led8),         32'd0);
    check({tag, "_cntd"}, 32'(dutd.count_r), 32'd0);
    check({tag, "_ledd"}, 32'(ledd),         32'd0);
  endtask

  task automatic run_edges(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check_all();
    end
  endtask

  // Called at a falling edge: assert rst between edges, confirm the clear is
  // immediate, hold it across a rising edge, then release at the next falling edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset({tag, "_imm"});
    @(negedge clk);
    check_reset({tag, "_hold"});
    rst = 1'b0;
    n = 0;
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check_reset("por");
    @(posedge clk);
    #1;
    check_reset("por_e1");
    @(posedge clk);
    #1;
    check_reset("por_e2");
    @(negedge clk);
    rst = 1'b0;
    n = 0;

    run_edges(30);

    // Land mid-count on the NUM_COUNT=5 instance: count_r=3, led=1.
    async_reset("rst0");
    run_edges(8);
    check("mid_cnt5", 32'(dut.count_r), 32'd3);
    check("mid_led5", 32'(led5),        32'd1);
    async_reset("mid");
    run_edges(20);

    for (int k = 0; k < 10; k++) begin
      run_edges(int'($urandom_range(1, 40)));
      async_reset("rnd");
    end
    run_edges(17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
